// File: rtl/brent_kung_subtractor_pipe.sv
// Two-stage pipelined subtractor (op1 - op2 - bin) on a Brent-Kung prefix carry network.
// Stage 1 registers the bitwise terms plus prefix up-sweep; stage 2 completes the down-sweep and flags.

module gp_unit (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);
   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;
endmodule

module brent_kung_subtractor_pipe #(
   parameter int ADDER_SIZE = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDER_SIZE-1:0] in_op1,
   input  logic [ADDER_SIZE-1:0] in_op2,
   input  logic                  bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDER_SIZE-1:0] out_res,
   output logic                  bout,
   output logic                  out_ovf,
   output logic                  out_zero
);
   localparam int W   = ADDER_SIZE;
   localparam int LVL = $clog2(ADDER_SIZE);

   logic [W-1:0] pb, gb;
   logic         cin;
   logic [LVL:0][W-1:0] ug, up;

   // Subtraction as op1 + ~op2 + ~bin; carry-in folded into bit 0 generate.
   assign pb  = in_op1 ^ ~in_op2;
   assign gb  = in_op1 & ~in_op2;
   assign cin = ~bin;
   assign ug[0] = {gb[W-1:1], gb[0] | (pb[0] & cin)};
   assign up[0] = pb;

   for (genvar l = 1; l <= LVL; l++) begin : g_up
      for (genvar i = 0; i < W; i++) begin : g_bit
         if (((i + 1) % (1 << l)) == 0) begin : g_node
            gp_unit u_gp (
               .g_hi (ug[l-1][i]),
               .p_hi (up[l-1][i]),
               .g_lo (ug[l-1][i-(1<<(l-1))]),
               .p_lo (up[l-1][i-(1<<(l-1))]),
               .g_out(ug[l][i]),
               .p_out(up[l][i])
            );
         end else begin : g_pass
            assign ug[l][i] = ug[l-1][i];
            assign up[l][i] = up[l-1][i];
         end
      end
   end

   logic         s1_v_q, s1_v_d;
   logic [W-1:0] s1_g_q, s1_g_d, s1_p_q, s1_p_d, s1_pb_q, s1_pb_d;
   logic         s1_cin_q, s1_cin_d, s1_sa_q, s1_sa_d, s1_sb_q, s1_sb_d;
   logic         s2_v_q, s2_v_d;
   logic [W-1:0] res_q, res_d;
   logic         bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic         s1_adv, s2_adv, accept;

   logic [LVL-1:0][W-1:0] dg, dp;
   assign dg[0] = s1_g_q;
   assign dp[0] = s1_p_q;

   // Down-sweep fills in the prefixes the up-sweep left partial.
   for (genvar k = 1; k < LVL; k++) begin : g_dn
      localparam int L = LVL - k;
      localparam int H = 1 << (L - 1);
      for (genvar i = 0; i < W; i++) begin : g_bit
         if ((i >= (1 << L)) && (((i + 1) % (1 << L)) == H)) begin : g_node
            gp_unit u_gp (
               .g_hi (dg[k-1][i]),
               .p_hi (dp[k-1][i]),
               .g_lo (dg[k-1][i-H]),
               .p_lo (dp[k-1][i-H]),
               .g_out(dg[k][i]),
               .p_out(dp[k][i])
            );
         end else begin : g_pass
            assign dg[k][i] = dg[k-1][i];
            assign dp[k][i] = dp[k-1][i];
         end
      end
   end

   logic [W-1:0] carry, sum;
   logic         unused_dp;
   assign carry     = {dg[LVL-1][W-2:0], s1_cin_q};
   assign sum       = s1_pb_q ^ carry;
   assign unused_dp = ^dp[LVL-1];

   assign s2_adv   = !s2_v_q || out_ready;
   assign s1_adv   = s1_v_q && s2_adv;
   assign in_ready = !rst && (!s1_v_q || s1_adv);
   assign accept   = in_valid && in_ready;

   always_comb begin
      s1_v_d   = accept || (s1_v_q && !s1_adv);
      s1_g_d   = s1_g_q;
      s1_p_d   = s1_p_q;
      s1_pb_d  = s1_pb_q;
      s1_cin_d = s1_cin_q;
      s1_sa_d  = s1_sa_q;
      s1_sb_d  = s1_sb_q;
      s2_v_d   = s2_v_q;
      res_d    = res_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      if (accept) begin
         s1_g_d   = ug[LVL];
         s1_p_d   = up[LVL];
         s1_pb_d  = pb;
         s1_cin_d = cin;
         s1_sa_d  = in_op1[W-1];
         s1_sb_d  = in_op2[W-1];
      end
      if (s2_adv) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            res_d  = sum;
            bout_d = ~dg[LVL-1][W-1];
            ovf_d  = (s1_sa_q != s1_sb_q) && (sum[W-1] != s1_sa_q);
            zero_d = (sum == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q   <= 1'b0;
         s1_g_q   <= '0;
         s1_p_q   <= '0;
         s1_pb_q  <= '0;
         s1_cin_q <= 1'b0;
         s1_sa_q  <= 1'b0;
         s1_sb_q  <= 1'b0;
         s2_v_q   <= 1'b0;
         res_q    <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         s1_v_q   <= s1_v_d;
         s1_g_q   <= s1_g_d;
         s1_p_q   <= s1_p_d;
         s1_pb_q  <= s1_pb_d;
         s1_cin_q <= s1_cin_d;
         s1_sa_q  <= s1_sa_d;
         s1_sb_q  <= s1_sb_d;
         s2_v_q   <= s2_v_d;
         res_q    <= res_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign out_valid = s2_v_q;
   assign out_res   = res_q;
   assign bout      = bout_q;
   assign out_ovf   = ovf_q;
   assign out_zero  = zero_q;
endmodule

// File: tb/tb_brent_kung_subtractor_pipe.sv
// Scoreboard bench for brent_kung_subtractor_pipe: directed corner cases, stall, reset flush, random traffic.

module tb_brent_kung_subtractor_pipe;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, bin, out_valid, out_ready;
   logic        bout, out_ovf, out_zero;
   logic [31:0] in_op1, in_op2, out_res;

   typedef struct packed {
      logic [31:0] res;
      logic        bout;
      logic        ovf;
      logic        zero;
   } exp_t;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic        bi;
      logic [31:0] res;
      logic        bout;
      logic        ovf;
      logic        zero;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   brent_kung_subtractor_pipe #(.ADDER_SIZE(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .bout(bout), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
      logic [32:0] d;
      exp_t        e;
      d      = {1'b0, a} - {1'b0, b} - {32'd0, bi};
      e.res  = d[31:0];
      e.bout = d[32];
      e.ovf  = (a[31] != b[31]) && (d[31] != a[31]);
      e.zero = (d[31:0] == 32'd0);
      return e;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_op1 = 32'd9; in_op2 = 32'd4; bin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_handshake got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
      end
      total++;
      if (out_res !== 32'd0 || bout !== 1'b0 || out_ovf !== 1'b0 || out_zero !== 1'b0) begin
         bad++; $display("FAIL reset_outputs got res=%h b=%b v=%b z=%b exp all zero", out_res, bout, out_ovf, out_zero);
      end
      repeat (3) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_no_accept got out_valid=%b exp=0", out_valid);
      end
   endtask

   task automatic test_directed();
      vec_t v[5];
      v[0] = '{32'd5,        32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
      v[1] = '{32'd0,        32'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      v[2] = '{32'd7,        32'd7, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
      v[3] = '{32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      v[4] = '{32'd0,        32'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         out_ready = 1'b1; in_valid = 1'b1;
         in_op1 = v[n].op1; in_op2 = v[n].op2; bin = v[n].bi;
         @(negedge clk);
         total++;
         if (in_ready !== 1'b1) begin
            bad++; $display("FAIL dir%0d_in_ready got=%b exp=1", n, in_ready);
         end
         @(posedge clk); #1;
         in_valid = 1'b0; in_op1 = $urandom; in_op2 = $urandom; bin = 1'b1;
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin
            bad++; $display("FAIL dir%0d_early_valid got=%b exp=0", n, out_valid);
         end
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_res !== v[n].res || bout !== v[n].bout ||
             out_ovf !== v[n].ovf || out_zero !== v[n].zero) begin
            bad++;
            $display("FAIL dir%0d_result got v=%b res=%h b=%b o=%b z=%b exp v=1 res=%h b=%b o=%b z=%b",
                     n, out_valid, out_res, bout, out_ovf, out_zero, v[n].res, v[n].bout, v[n].ovf, v[n].zero);
         end
      end
   endtask

   task automatic test_back_to_back_stall();
      logic [31:0] a1[3], a2[3];
      int          k = 0;
      int          cyc;
      a1[0] = 32'd100; a2[0] = 32'd1;
      a1[1] = 32'd3;   a2[1] = 32'd50;
      a1[2] = 32'h7FFFFFFF; a2[2] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (cyc = 0; cyc < 5; cyc++) begin
         in_valid = (k < 3); bin = 1'b0;
         if (k < 3) begin in_op1 = a1[k]; in_op2 = a2[k]; end
         @(negedge clk);
         if (cyc >= 2) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sb.size() == 0 || out_res !== sb[0].res ||
                bout !== sb[0].bout) begin
               bad++;
               $display("FAIL stall_hold cyc%0d got in_ready=%b out_valid=%b res=%h b=%b exp 0 1 res=%h b=%b",
                        cyc, in_ready, out_valid, out_res, bout, (sb.size() > 0) ? sb[0].res : 32'd0,
                        (sb.size() > 0) ? sb[0].bout : 1'b0);
            end
         end
         if (in_valid && in_ready) begin sb.push_back(model(a1[k], a2[k], 1'b0)); k++; end
         @(posedge clk); #1;
      end
      total++;
      if (k !== 2) begin
         bad++; $display("FAIL stall_accept_count got=%0d exp=2", k);
      end
      out_ready = 1'b1;
      for (cyc = 0; cyc < 20 && (k < 3 || sb.size() > 0); cyc++) begin
         in_valid = (k < 3);
         if (k < 3) begin in_op1 = a1[k]; in_op2 = a2[k]; end
         @(negedge clk);
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL stall_unexpected_out got res=%h exp no output", out_res);
            end else begin
               exp_t e = sb.pop_front();
               if (out_res !== e.res || bout !== e.bout || out_ovf !== e.ovf || out_zero !== e.zero) begin
                  bad++;
                  $display("FAIL stall_order got res=%h b=%b o=%b z=%b exp res=%h b=%b o=%b z=%b",
                           out_res, bout, out_ovf, out_zero, e.res, e.bout, e.ovf, e.zero);
               end
            end
         end
         if (in_valid && in_ready) begin sb.push_back(model(a1[k], a2[k], 1'b0)); k++; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (k !== 3 || sb.size() != 0) begin
         bad++; $display("FAIL stall_drain got accepted=%0d pending=%0d exp 3 0", k, sb.size());
      end
   endtask

   task automatic test_reset_flush();
      logic seen = 1'b0;
      out_ready = 1'b0;
      for (int n = 0; n < 2; n++) begin
         in_valid = 1'b1; in_op1 = 32'd40 + n; in_op2 = 32'd2; bin = 1'b0;
         @(negedge clk);
         total++;
         if (in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_fill%0d in_ready got=%b exp=1", n, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== 32'd0) begin
         bad++; $display("FAIL flush_after_reset got out_valid=%b in_ready=%b res=%h exp 0 1 0", out_valid, in_ready, out_res);
      end
      out_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL flush_stale_beat got out_valid seen=%b exp=0", seen);
      end
   endtask

   task automatic test_random();
      int sent = 0;
      int cyc;
      logic [31:0] a, b;
      logic        bi;
      for (cyc = 0; cyc < 60000 && (sent < 10000 || sb.size() > 0); cyc++) begin
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
            2: begin a = 32'h80000000 ^ $urandom_range(0, 3); b = $urandom_range(0, 3) ^ 32'h7FFFFFFF; end
            default: begin a = $urandom; b = a; end
         endcase
         bi        = 1'($urandom_range(0, 1));
         in_op1    = a; in_op2 = b; bin = bi;
         in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL rand_unexpected_out got res=%h exp no output", out_res);
            end else begin
               exp_t e = sb.pop_front();
               if (out_res !== e.res || bout !== e.bout || out_ovf !== e.ovf || out_zero !== e.zero) begin
                  bad++;
                  $display("FAIL rand_result got res=%h b=%b o=%b z=%b exp res=%h b=%b o=%b z=%b",
                           out_res, bout, out_ovf, out_zero, e.res, e.bout, e.ovf, e.zero);
               end
            end
         end
         if (in_valid && in_ready) begin sb.push_back(model(a, b, bi)); sent++; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (sent != 10000 || sb.size() != 0) begin
         bad++; $display("FAIL rand_complete got sent=%0d pending=%0d exp 10000 0", sent, sb.size());
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back_stall();
      test_reset_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
